// File: rtl/stream_mem_pkg.sv
// Shared definitions for the stream memory responder.
// Latency bound and the byte-enable merge helper.
package stream_mem_pkg;

  localparam int MaxLatency = 8;
  localparam int MaxDataWidth = 256;

  typedef logic [MaxDataWidth-1:0] word_t;
  typedef logic [MaxDataWidth/8-1:0] be_t;

  function automatic word_t be_merge(
    input word_t old_w,
    input word_t new_w,
    input be_t   be
  );
    word_t res;
    for (int i = 0; i < MaxDataWidth / 8; i++) begin
      res[i*8 +: 8] = be[i] ? new_w[i*8 +: 8]
                            : old_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_mem_delay.sv
// Resettable valid/payload delay line for responses.
// Depth of zero degenerates to a zeroing pass-through.
module stream_mem_delay #(
  parameter int  Depth = 1,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o,
  output logic busy_o
);

  if (Depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign valid_o = valid_i;
    assign data_o  = valid_i ? data_i : T'('0);
    assign busy_o  = 1'b0;
  end else begin : g_pipe
    logic [Depth-1:0] vld_q;
    T                 dat_q [Depth];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int i = 0; i < Depth; i++) begin
          dat_q[i] <= T'('0);
        end
      end else begin
        vld_q[0] <= valid_i;
        dat_q[0] <= valid_i ? data_i : T'('0);
        for (int i = 1; i < Depth; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign valid_o = vld_q[Depth-1];
    assign data_o  = dat_q[Depth-1];
    assign busy_o  = |vld_q;
  end

endmodule

// File: rtl/stream_mem_responder.sv
// Memory-side responder: byte-enabled word storage with
// fixed-latency in-order responses and no response ready.
module stream_mem_responder
  import stream_mem_pkg::*;
#(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  parameter int AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   mem_req_valid_i,
  output logic                   mem_req_ready_o,
  input  logic                   mem_req_we_i,
  input  logic [AddrWidth-1:0]   mem_req_addr_i,
  input  logic [DataWidth-1:0]   mem_req_wdata_i,
  input  logic [DataWidth/8-1:0] mem_req_be_i,
  output logic                   mem_resp_valid_o,
  output logic [DataWidth-1:0]   mem_resp_rdata_o,
  output logic                   mem_resp_err_o,
  output logic                   busy_o
);

  localparam int IdxW  = $clog2(NumWords);
  localparam int Depth = (Latency > MaxLatency) ? MaxLatency
                                                : Latency;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } resp_t;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic                 accept;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] wr_word;
  resp_t                req_resp;
  resp_t                out_resp;

  assign mem_req_ready_o = !rst_i && !stall_i;
  assign accept   = mem_req_valid_i && mem_req_ready_o;
  assign in_range = 64'(mem_req_addr_i) < 64'(NumWords);
  assign idx      = mem_req_addr_i[IdxW-1:0];
  assign rd_word  = in_range ? mem_q[idx] : '0;

  assign wr_word = DataWidth'(be_merge(
    word_t'(rd_word),
    word_t'(mem_req_wdata_i),
    be_t'(mem_req_be_i)));

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (accept && mem_req_we_i && in_range) begin
      mem_q[idx] <= wr_word;
    end
  end

  assign req_resp.rdata = mem_req_we_i ? '0 : rd_word;
  assign req_resp.err   = !in_range;

  stream_mem_delay #(
    .Depth (Depth),
    .T     (resp_t)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept),
    .data_i  (req_resp),
    .valid_o (mem_resp_valid_o),
    .data_o  (out_resp),
    .busy_o  (busy_o)
  );

  assign mem_resp_rdata_o = out_resp.rdata;
  assign mem_resp_err_o   = out_resp.err;

endmodule
